// File: rtl/dffram_bist_pkg.sv
// dffram_bist_pkg: shared types and constants for the DFFRAM March C- BIST.
// Contents: state_t (controller states), DATA_WIDTH, background patterns P0/P1.
// Macro DFFRAM_BIST_CHECKERBOARD_EN selects checkerboard backgrounds instead of solid 0/1.
package dffram_bist_pkg;
    localparam int DATA_WIDTH = 32;
`ifdef DFFRAM_BIST_CHECKERBOARD_EN
    localparam logic [DATA_WIDTH-1:0] P0 = 32'h5555_5555;
    localparam logic [DATA_WIDTH-1:0] P1 = 32'hAAAA_AAAA;
`else
    localparam logic [DATA_WIDTH-1:0] P0 = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] P1 = 32'hFFFF_FFFF;
`endif
    // Pass states are contiguous so the next pass is simply state + 1.
    typedef enum logic [3:0] {
        S_IDLE, S_W0, S_M1, S_M2, S_M3, S_M4, S_R0, S_DRAIN, S_DONE
    } state_t;
endpackage

// File: rtl/dffram_bist_if.sv
// dffram_bist_if: host control/status plus DFFRAM single-port signals of the BIST.
// master: BIST side (drives RAM port and status, receives start and Do0).
// slave:  host + RAM side (drives start and Do0, receives the rest).
interface dffram_bist_if #(parameter int A_WIDTH = 8);
    logic                                   start;
    logic                                   busy;
    logic                                   done;
    logic                                   fail;
    logic [A_WIDTH-1:0]                     fail_addr;
    logic [dffram_bist_pkg::DATA_WIDTH-1:0] fail_syndrome;
    logic                                   EN0;
    logic [3:0]                             WE0;
    logic [dffram_bist_pkg::DATA_WIDTH-1:0] Di0;
    logic [A_WIDTH-1:0]                     A0;
    logic [dffram_bist_pkg::DATA_WIDTH-1:0] Do0;
    modport master (input start, Do0,
                    output busy, done, fail, fail_addr, fail_syndrome, EN0, WE0, Di0, A0);
    modport slave  (output start, Do0,
                    input busy, done, fail, fail_addr, fail_syndrome, EN0, WE0, Di0, A0);
endinterface

// File: rtl/dffram_bist_addr_gen.sv
// dffram_bist_addr_gen: up/down word address counter with load and terminal-count flag.
// Ports: CLK, RST (sync, active-high), i_en (step), i_up (direction), i_load/i_load_val
// (load has priority over step), o_addr (current address), o_tc (last address of this direction).
module dffram_bist_addr_gen #(parameter int A_WIDTH = 8) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_en,
    input  logic               i_up,
    input  logic               i_load,
    input  logic [A_WIDTH-1:0] i_load_val,
    output logic [A_WIDTH-1:0] o_addr,
    output logic               o_tc
);
    logic [A_WIDTH-1:0] r_addr;
    always_ff @(posedge CLK) begin
        if (RST)
            r_addr <= '0;
        else if (i_load)
            r_addr <= i_load_val;
        else if (i_en)
            r_addr <= i_up ? r_addr + 1'b1 : r_addr - 1'b1;
    end
    assign o_addr = r_addr;
    assign o_tc   = i_up ? &r_addr : ~|r_addr;
endmodule

// File: rtl/dffram_bist.sv
// dffram_bist: March C- BIST controller driving a DFFRAM single port.
// Ports: CLK, RST (sync, active-high), bus (dffram_bist_if.master: start/busy/done/fail,
// fail_addr, fail_syndrome, RAM port EN0/WE0/Di0/A0/Do0).
// Macro DFFRAM_BIST_CHECKERBOARD_EN (in dffram_bist_pkg) selects checkerboard backgrounds.
module dffram_bist
    import dffram_bist_pkg::*;
#(
    parameter int A_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    dffram_bist_if.master  bus
);
    state_t                r_state, w_next;
    logic                  w_idle, w_pass, w_rd, w_desc, w_accept, w_tc, w_load;
    logic [A_WIDTH-1:0]    w_addr, w_load_val;
    logic [DATA_WIDTH-1:0] w_exp, w_wdata, w_syn;
    logic                  r_cmp_vld;
    logic [A_WIDTH-1:0]    r_cmp_addr;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic                  r_fail;
    logic [A_WIDTH-1:0]    r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_syn;

    assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_pass   = (r_state >= S_W0) && (r_state <= S_R0);
    assign w_rd     = (r_state >= S_M1) && (r_state <= S_R0);
    assign w_desc   = (r_state == S_M3) || (r_state == S_M4);
    assign w_accept = w_idle && bus.start;
    assign w_exp    = (r_state == S_M2 || r_state == S_M4) ? P1 : P0;
    assign w_wdata  = (r_state == S_M1 || r_state == S_M3) ? P1 : P0;
    assign w_syn    = bus.Do0 ^ r_cmp_exp;

    dffram_bist_addr_gen #(.A_WIDTH(A_WIDTH)) u_addr (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (w_pass),
        .i_up       (!w_desc),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_addr     (w_addr),
        .o_tc       (w_tc)
    );

    // Each pass hands over to the next on terminal count; descending passes start at N-1.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_accept) begin
            w_next = S_W0;
            w_load = 1'b1;
        end else if (w_pass && w_tc) begin
            w_next     = state_t'(r_state + 4'd1);
            w_load     = 1'b1;
            w_load_val = (w_next == S_M3 || w_next == S_M4) ? '1 : '0;
        end else if (r_state == S_DRAIN) begin
            w_next = S_DONE;
        end
    end

    // Reads register their expectation; the following cycle compares the returned Do0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cmp_vld   <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_exp   <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_syn  <= '0;
        end else begin
            r_state    <= w_next;
            r_cmp_vld  <= w_rd;
            r_cmp_addr <= w_addr;
            r_cmp_exp  <= w_exp;
            if (w_accept) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_syn  <= '0;
            end else if (r_cmp_vld && |w_syn && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_fail_syn  <= w_syn;
            end
        end
    end

    assign bus.busy          = !w_idle;
    assign bus.done          = (r_state == S_DONE);
    assign bus.fail          = r_fail;
    assign bus.fail_addr     = r_fail_addr;
    assign bus.fail_syndrome = r_fail_syn;
    assign bus.EN0           = w_pass;
    assign bus.WE0           = (w_pass && r_state != S_R0) ? 4'hF : 4'h0;
    assign bus.Di0           = (w_pass && r_state != S_R0) ? w_wdata : '0;
    assign bus.A0            = w_pass ? w_addr : '0;
endmodule

// File: tb/tb_dffram_bist.sv
// tb_dffram_bist: self-checking bench for dffram_bist with a faultable DFFRAM model.
module tb_dffram_bist;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dffram_bist_if #(.A_WIDTH(8)) bus();
    dffram_bist #(.A_WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus));

    logic [31:0] mem [256];
    bit f_stuck, f_couple, f_short;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] wfix(input logic [7:0] a, input logic [31:0] d);
        return (f_short && a == 8'h00) ? {d[31:2], {2{d[1] & d[0]}}} : d;
    endfunction

    // Read-before-write RAM; faults: bit5 of 0x2A stuck-at-1, write 0x10 also hits 0x11,
    // wired-AND short between bits 0 and 1 of word 0x00.
    always @(posedge clk) begin
        if (bus.EN0) begin
            bus.Do0 <= mem[bus.A0] | ((f_stuck && bus.A0 == 8'h2A) ? 32'h20 : 32'h0);
            for (int b = 0; b < 4; b++)
                if (bus.WE0[b]) begin
                    mem[bus.A0][8*b +: 8] <= wfix(bus.A0, bus.Di0) >> (8*b);
                    if (f_couple && bus.A0 == 8'h10) mem[8'h11][8*b +: 8] <= bus.Di0 >> (8*b);
                end
        end else begin
            bus.Do0 <= '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run(input bit pre, input int repulse, input int rst_at,
                       output int dcyc, output int bcnt, output int fcyc);
        int k;
        if (!pre) begin
            @(negedge clk) bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        k = 1; dcyc = 0; bcnt = 0; fcyc = 0;
        while (k <= 2000 && dcyc == 0) begin
            if (bus.busy) bcnt++;
            if (bus.fail && fcyc == 0) fcyc = k;
            if (bus.done) dcyc = k;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            bus.start = (k == repulse);
            @(posedge clk);
            #1 k++;
        end
    endtask

    typedef struct {
        bit          stuck, couple, shrt;
        logic        exp_fail;
        logic [7:0]  exp_addr;
        logic [31:0] exp_syn;
        int          exp_fcyc;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int dcyc, bcnt, fcyc;
        vecs[0] = '{0, 0, 0, 1'b0, 8'h00, 32'h0000_0000, 0};
        vecs[1] = '{1, 0, 0, 1'b1, 8'h2A, 32'h0000_0020, 301};
        vecs[2] = '{0, 1, 0, 1'b1, 8'h11, 32'hFFFF_FFFF, 276};
        vecs[3] = '{1, 1, 0, 1'b1, 8'h11, 32'hFFFF_FFFF, 276};
`ifdef DFFRAM_BIST_CHECKERBOARD_EN
        vecs[4] = '{0, 0, 1, 1'b1, 8'h00, 32'h0000_0001, 259};
`else
        vecs[4] = '{0, 0, 1, 1'b0, 8'h00, 32'h0000_0000, 0};
`endif
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_status", {bus.busy, bus.done, bus.fail, bus.fail_addr, bus.fail_syndrome}, '0);
        chk("rst_ram", {bus.EN0, bus.WE0, bus.A0, bus.Di0}, '0);

        for (int i = 0; i < 5; i++) begin
            f_stuck = vecs[i].stuck; f_couple = vecs[i].couple; f_short = vecs[i].shrt;
            run(0, 0, 0, dcyc, bcnt, fcyc);
            chk($sformatf("v%0d_done_cyc", i), dcyc, 1538);
            chk($sformatf("v%0d_busy_cnt", i), bcnt, 1537);
            chk($sformatf("v%0d_fail", i), bus.fail, vecs[i].exp_fail);
            chk($sformatf("v%0d_fail_addr", i), bus.fail_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_syndrome", i), bus.fail_syndrome, vecs[i].exp_syn);
            chk($sformatf("v%0d_fail_cyc", i), fcyc, vecs[i].exp_fcyc);
        end

        f_stuck = 1; f_couple = 0; f_short = 0;
        run(0, 0, 800, dcyc, bcnt, fcyc);
        chk("mid_rst_fail_before", fcyc, 301);
        chk("mid_rst_outputs", {bus.busy, bus.EN0, bus.WE0, bus.done, bus.fail}, '0);
        f_stuck = 0;
        run(0, 0, 0, dcyc, bcnt, fcyc);
        chk("after_rst_done_cyc", dcyc, 1538);
        chk("after_rst_fail", bus.fail, 1'b0);

        f_stuck = 1;
        run(0, 100, 0, dcyc, bcnt, fcyc);
        chk("repulse_done_cyc", dcyc, 1538);
        chk("repulse_busy_cnt", bcnt, 1537);
        chk("repulse_fail_addr", bus.fail_addr, 8'h2A);
        f_stuck = 0;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("restart_cleared", {bus.done, bus.fail, bus.fail_addr, bus.fail_syndrome}, '0);
        chk("restart_busy", bus.busy, 1'b1);
        run(1, 0, 0, dcyc, bcnt, fcyc);
        chk("restart_done_cyc", dcyc, 1538);
        chk("restart_fail", bus.fail, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
